// File: rtl/rr_issue_arbiter.sv
// Round-robin issue arbiter: one FU issue port shared by N_REQ RS entries, registered grant
// with valid/stall handshake, optional FU occupancy and squash. Optional perf counters: ARB_PERF_CNT_EN.
module rr_issue_arbiter #(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int BUSY_CYC = 0,
    parameter int BUSY_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic [N_REQ-1:0]  req,
    input  logic              fu_stall,
    output logic [N_REQ-1:0]  gnt,
    output logic              gnt_valid,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic [IDX_W-1:0]  ptr
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_acc_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // state | meaning
    // IDLE  | no grant outstanding, sampling req
    // GRANT | gnt/gnt_idx valid, held until accepted
    // BUSY  | FU occupied after an accept, no grant issued
    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BUSY_W-1:0]  cnt_q, cnt_d;

    logic               accept;
    logic [IDX_W-1:0]   ptr_acc;
    logic [IDX_W-1:0]   ptr_sel;
    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   mask;
    logic [N_REQ-1:0]   cand_hi;
    logic [N_REQ-1:0]   win_src;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;

    assign accept  = gnt_valid_q & ~fu_stall;
    assign ptr_acc = gnt_idx_q - IDX_W'(1);

    // A back-to-back pick in GRANT must already see the pointer the accept is moving to.
    assign ptr_sel = (state_q == GRANT) ? ptr_acc : ptr_q;

    always_comb begin
        cand = '0;
        case (state_q)
            IDLE:    cand = req;
            GRANT:   cand = req & ~gnt_q;
            default: cand = '0;
        endcase
    end

    always_comb begin
        mask    = '0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (IDX_W'(i) <= ptr_sel);
        end
        cand_hi = cand & mask;
        win_src = (|cand_hi) ? cand_hi : cand;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_src[i]) win_idx = IDX_W'(i);
        end
        win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    gnt_d       = win_oh;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    ptr_d       = ptr_acc;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    if (BUSY_CYC == 0) begin
                        if (|cand) begin
                            gnt_d       = win_oh;
                            gnt_idx_d   = win_idx;
                            gnt_valid_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = BUSY_W'(BUSY_CYC);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - BUSY_W'(1);
                if (cnt_q <= BUSY_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Squash beats a same-cycle accept, so the pointer is left where it was.
        if (squash) begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_idx_d   = '0;
            cnt_d       = '0;
            ptr_d       = ptr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign ptr       = ptr_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] acc_cnt_q, acc_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) acc_cnt_d = acc_cnt_q + 32'd1;
        if (gnt_valid_q & fu_stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_acc_cnt   = acc_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
